// File: rtl/rot_encode_gen.sv
`default_nettype none
// ============================================================================
// Module      : rot_encode_gen
// Description : Quadrature rotary-encoder waveform generator. Step commands
//               (one direction bit per detent) are queued in a small FIFO and
//               each one is played out as a full gray-code detent cycle on
//               rotA/rotB:
//                   CW  : 00 -> 10 -> 11 -> 01 -> 00   (A leads B)
//                   CCW : 00 -> 01 -> 11 -> 10 -> 00   (B leads A)
//               Each phase is held PHASE_CYCLES clocks. After the final 00
//               phase the FSM spends one cycle in IDLE, during which done
//               pulses high, so back-to-back detents repeat every
//               4*PHASE_CYCLES+1 clocks.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active-high
//               step_valid - step command present
//               step_dir   - 1 = CW/right, 0 = CCW/left (sampled with valid)
//               step_ready - queue can accept a command (= !full)
//               rotA/rotB  - registered encoder channels
//               busy       - FSM active or commands still queued
//               pending    - queued commands not yet started
//               done       - one-cycle pulse as a detent cycle completes
// Revision    : 1.0 - initial release
// ============================================================================
module rot_encode_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int TMR_W        = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step_valid,
    input  logic                          step_dir,
    output logic                          step_ready,
    output logic                          rotA,
    output logic                          rotB,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] c_TMR_LOAD = TMR_W'(PHASE_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PH1  = 3'd1;
    localparam logic [2:0] c_ST_PH2  = 3'd2;
    localparam logic [2:0] c_ST_PH3  = 3'd3;
    localparam logic [2:0] c_ST_GAP  = 3'd4;

    // ------------------------------------------------------------------------
    // Step command FIFO
    // ------------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] r_fifo;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Ready depends on fullness only; a pop on the same edge does not make
    // room for a push into a full queue.
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = step_valid && !w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= step_dir;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Detent FSM
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_dir;
    logic             r_rot_a;
    logic             r_rot_b;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_dir_nxt;
    logic [1:0]       w_ab_nxt;
    logic             w_done_nxt;
    logic             w_tmr_zero;

    assign w_tmr_zero = (r_timer == '0);

    // The head entry is consumed only when IDLE starts a new detent.
    assign w_pop = (r_state == c_ST_IDLE) && !w_empty;

    // State register. The channel outputs and done are registered here too,
    // so they change exactly on the edge that enters the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
            r_rot_a <= 1'b0;
            r_rot_b <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_dir   <= w_dir_nxt;
            r_rot_a <= w_ab_nxt[1];
            r_rot_b <= w_ab_nxt[0];
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: each active phase holds for PHASE_CYCLES edges
    // (timer counts PHASE_CYCLES-1 down to 0, then the phase advances).
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = c_ST_PH1;
                    w_timer_nxt = c_TMR_LOAD;
                    // Direction is captured from the queue at pop time, so a
                    // later change on step_dir cannot disturb this detent.
                    w_dir_nxt   = r_fifo[r_rptr];
                end
            end
            c_ST_PH1: begin
                if (w_tmr_zero) begin
                    w_state_nxt = c_ST_PH2;
                    w_timer_nxt = c_TMR_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            c_ST_PH2: begin
                if (w_tmr_zero) begin
                    w_state_nxt = c_ST_PH3;
                    w_timer_nxt = c_TMR_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            c_ST_PH3: begin
                if (w_tmr_zero) begin
                    w_state_nxt = c_ST_GAP;
                    w_timer_nxt = c_TMR_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            c_ST_GAP: begin
                if (w_tmr_zero) begin
                    w_state_nxt = c_ST_IDLE;
                    w_timer_nxt = c_TMR_LOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Output logic: the channel code is a function of the state being
    // entered and the direction that goes with it, giving a gray sequence
    // (only one channel changes per phase boundary).
    always_comb begin
        w_ab_nxt   = 2'b00;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            c_ST_PH1: w_ab_nxt = w_dir_nxt ? 2'b10 : 2'b01;
            c_ST_PH2: w_ab_nxt = 2'b11;
            c_ST_PH3: w_ab_nxt = w_dir_nxt ? 2'b01 : 2'b10;
            default:  w_ab_nxt = 2'b00;
        endcase
        // The completion pulse lands on the single IDLE cycle after GAP.
        if ((r_state == c_ST_GAP) && w_tmr_zero) begin
            w_done_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign step_ready = !w_full;
    assign rotA       = r_rot_a;
    assign rotB       = r_rot_b;
    assign done       = r_done;
    assign pending    = r_count;
    assign busy       = (r_state != c_ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_rot_encode_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_encode_gen
// Description : Self-checking bench for rot_encode_gen. A behavioural model
//               tracks queued steps and the position within the current
//               detent and predicts rotA/rotB, done, pending, busy and
//               step_ready after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_encode_gen;

    localparam int P     = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       step_valid;
    logic       step_dir;
    logic       step_ready;
    logic       rotA;
    logic       rotB;
    logic       busy;
    logic [2:0] pending;
    logic       done;

    rot_encode_gen #(
        .PHASE_CYCLES (P),
        .TMR_W        (16),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_ready (step_ready),
        .rotA       (rotA),
        .rotB       (rotB),
        .busy       (busy),
        .pending    (pending),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_q[$];
    bit         m_active;
    bit         m_dir;
    bit         m_done;
    int         m_k;        // cycles elapsed inside the current detent
    logic [1:0] prev_ab;
    int         n_done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Channel code for phase index 0..3 of a detent
    function automatic logic [1:0] code(input bit dir, input int ph);
        case (ph)
            0:       return dir ? 2'b10 : 2'b01;
            1:       return 2'b11;
            2:       return dir ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_dir    = 1'b0;
        m_done   = 1'b0;
        m_k      = 0;
    endtask

    // Advance the model across one rising edge using pre-edge state.
    task automatic model_edge(input bit v, input bit d);
        bit full_pre;
        full_pre = (m_q.size() == DEPTH);
        m_done   = 1'b0;
        if (m_active) begin
            m_k++;
            if (m_k == 4 * P) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (m_q.size() > 0) begin
            m_dir    = m_q.pop_front();
            m_active = 1'b1;
            m_k      = 0;
        end
        if (v && !full_pre) m_q.push_back(d);
    endtask

    task automatic check_all();
        logic [1:0] ab;
        logic [1:0] exp_ab;
        ab     = {rotA, rotB};
        exp_ab = m_active ? code(m_dir, m_k / P) : 2'b00;
        chk("ab",         ab,         exp_ab);
        chk("done",       done,       m_done);
        chk("pending",    pending,    m_q.size());
        chk("step_ready", step_ready, (m_q.size() < DEPTH));
        chk("busy",       busy,       (m_active || m_q.size() > 0));
        chk("gray_onebit", ($countones(ab ^ prev_ab) <= 1), 1'b1);
        if (done === 1'b1) n_done_seen++;
        prev_ab = ab;
    endtask

    task automatic cyc(input bit v, input bit d);
        step_valid = v;
        step_dir   = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        check_all();
    endtask

    initial begin
        int first_done;
        int start_done;
        rst         = 1'b1;
        step_valid  = 1'b0;
        step_dir    = 1'b0;
        prev_ab     = 2'b00;
        n_done_seen = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ab",      {rotA, rotB}, 2'b00);
        chk("rst_pending", pending,      3'd0);
        chk("rst_done",    done,         1'b0);
        chk("rst_ready",   step_ready,   1'b1);
        chk("rst_busy",    busy,         1'b0);
        rst = 1'b0;

        // Single CW detent with explicit timing from the accept edge
        cyc(1'b1, 1'b1);
        first_done = -1;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 1'b0);
            if (n == 1)  chk("cw_t1",  {rotA, rotB}, 2'b10);
            if (n == 5)  chk("cw_t5",  {rotA, rotB}, 2'b11);
            if (n == 9)  chk("cw_t9",  {rotA, rotB}, 2'b01);
            if (n == 13) chk("cw_t13", {rotA, rotB}, 2'b00);
            if (done === 1'b1 && first_done < 0) first_done = n;
        end
        chk("cw_done_cycle", first_done, 17);
        chk("cw_done_count", n_done_seen, 1);

        // Single CCW detent
        cyc(1'b1, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 1'b1);
            if (n == 1) chk("ccw_t1", {rotA, rotB}, 2'b01);
            if (n == 9) chk("ccw_t9", {rotA, rotB}, 2'b10);
        end
        chk("ccw_done_count", n_done_seen, 2);

        // Six back-to-back pushes into a depth-4 queue: the sixth is refused
        start_done = n_done_seen;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("burst_full_ready", step_ready, 1'b0);
        chk("burst_full_pend",  pending,    3'd4);
        cyc(1'b1, 1'b0);
        for (int n = 0; n < 5 * (4 * P + 1) + 4; n++) cyc(1'b0, 1'b0);
        chk("burst_done_count", n_done_seen - start_done, 5);

        // Async reset during PH2 of a CW detent with two steps queued
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0);
        chk("pre_rst_ab", {rotA, rotB}, 2'b11);
        start_done = n_done_seen;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_ab",      {rotA, rotB}, 2'b00);
        chk("mid_rst_pending", pending,      3'd0);
        chk("mid_rst_ready",   step_ready,   1'b1);
        chk("mid_rst_done",    done,         1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_ab", {rotA, rotB}, 2'b00);
        rst     = 1'b0;
        prev_ab = 2'b00;
        cyc(1'b1, 1'b0);
        for (int n = 0; n < 4 * P + 3; n++) cyc(1'b0, 1'b0);
        chk("post_rst_done_count", n_done_seen - start_done, 1);

        // Random push stream against the model with gray-code monitoring
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1);
        end
        for (int n = 0; n < (DEPTH + 1) * (4 * P + 1) + 2; n++) cyc(1'b0, 1'b0);
        chk("final_idle_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
